ibuf_mc_fifo: RTL

- Parametrised next-generation mesh-node input buffer: DEPTH-entry FIFO of {route mask, payload} per input port, replacing the single-entry buffer.
- Head flit raises per-direction arbitration requests to the NDIR output arbiters.
- Supports multicast: a head flit with several route bits set is retired only after every requested direction has been served, in any order and over any number of cycles.
- Sits between a link input and the node crossbar arbiters, one instance per input direction.

---
 rtl/node_pkg.sv | 21 ++
 rtl/ibuf_fifo_mem.sv | 38 +++
 rtl/ibuf_mc_fifo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/node_pkg.sv
// Shared mesh-node definitions.
//   - Output direction indices (N, W, S, E, B) into NDIR-wide masks.
//   - Default direction count and payload width.
//   - flit_t: the {route mask, payload} record for the default widths.
package node_pkg;

  localparam int DIR_N      = 0;
  localparam int DIR_W      = 1;
  localparam int DIR_S      = 2;
  localparam int DIR_E      = 3;
  localparam int DIR_B      = 4;

  localparam int NDIR_DEF   = 5;
  localparam int PYLD_W_DEF = 23;

  typedef struct packed {
    logic [NDIR_DEF-1:0]   mask;
    logic [PYLD_W_DEF-1:0] payload;
  } flit_t;

endpackage

// File: rtl/ibuf_fifo_mem.sv
// Storage array for the input-buffer FIFO.
// The array is DEPTH entries of W bits. It has one synchronous write
// port and one asynchronous read port.
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write index
//   wdata  in  write data
//   raddr  in  read index (the head entry)
//   rdata  out read data, combinational from raddr
module ibuf_fifo_mem
  import node_pkg::*;
#(
  parameter int W     = NDIR_DEF + PYLD_W_DEF,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port. The contents need no reset: validity is tracked by the
  // owner's count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Asynchronous read of the head entry.
  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ibuf_mc_fifo.sv
// Multicast-capable mesh-node input buffer. The design uses one
// instance per input direction.
// The block holds DEPTH flits of {route mask, payload}. The head flit
// requests every output direction in its mask that has not been served
// yet. The head flit retires once the last of those directions is served.
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   ibuf_vld   in  upstream flit valid
//   ibuf_rdy   out buffer can accept a flit
//   pg_en      in  power-gating enable
//   cpy_mode   in  copy mode (with pg_en, blocks input)
//   route_req  in  destination mask of the incoming flit
//   payload_i  in  incoming payload
//   arb_req    out outstanding requests of the head flit
//   arb_gnt    in  arbiter grants
//   obuf_rdy   in  output-buffer ready per direction
//   payload_o  out head payload (zero when empty)
//   occ        out stored entry count
//   drop_o     out one-cycle pulse after an accepted all-zero-mask flit
module ibuf_mc_fifo
  import node_pkg::*;
#(
  parameter int PYLD_W = PYLD_W_DEF,
  parameter int NDIR   = NDIR_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ibuf_vld,
  output logic                       ibuf_rdy,
  input  logic                       pg_en,
  input  logic                       cpy_mode,
  input  logic [NDIR-1:0]            route_req,
  input  logic [PYLD_W-1:0]          payload_i,
  output logic [NDIR-1:0]            arb_req,
  input  logic [NDIR-1:0]            arb_gnt,
  input  logic [NDIR-1:0]            obuf_rdy,
  output logic [PYLD_W-1:0]          payload_o,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = NDIR + PYLD_W;

  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic [NDIR-1:0]   done_r;
  logic              drop_r;

  logic [W-1:0]      rd_data_s;
  logic [NDIR-1:0]   head_mask_s;
  logic [PYLD_W-1:0] head_payload_s;
  logic              head_vld_s;
  logic              push_s;
  logic              wr_en_s;
  logic              zero_mask_s;
  logic [NDIR-1:0]   clr_s;
  logic              retire_s;

  ibuf_fifo_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata ({route_req, payload_i}),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  assign head_mask_s    = rd_data_s[PYLD_W +: NDIR];
  assign head_payload_s = rd_data_s[PYLD_W-1:0];
  assign head_vld_s     = (count_r != {CW{1'b0}});

  // The full check uses the registered count only, so a retire in the
  // same cycle never opens a slot (no pass-through).
  assign ibuf_rdy    = ~rst & (count_r != CW'(DEPTH)) & ~(pg_en & cpy_mode);
  assign push_s      = ibuf_vld & ibuf_rdy;
  assign zero_mask_s = (route_req == {NDIR{1'b0}});
  // A flit with no destination is consumed but never stored.
  assign wr_en_s     = push_s & ~zero_mask_s;

  assign arb_req   = head_vld_s ? (head_mask_s & ~done_r) : {NDIR{1'b0}};
  assign payload_o = head_vld_s ? head_payload_s : {PYLD_W{1'b0}};
  assign occ       = count_r;
  assign drop_o    = drop_r;

  // Only directions still requested can be served. This masks grants
  // on bits that are not requested.
  assign clr_s    = arb_gnt & obuf_rdy & arb_req;
  assign retire_s = head_vld_s & ((arb_req & ~clr_s) == {NDIR{1'b0}});

  // Next occupancy. A push and a retire in the same cycle cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, retire_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count, multicast served mask and the drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      done_r   <= {NDIR{1'b0}};
      drop_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      drop_r  <= push_s & zero_mask_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (retire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        done_r   <= {NDIR{1'b0}};
      end else begin
        rd_ptr_r <= rd_ptr_r;
        done_r   <= done_r | clr_s;
      end
    end
  end

endmodule
